// File: rtl/qspi_psram_ctrl.sv
// QSPI PSRAM master: single-word requests become Quad Write (0x38) / Fast Read Quad (0xEB).
// Define QSPI_INIT_RESET_EN to send Reset Enable (0x66) then Reset (0x99) after rst.
module qspi_psram_ctrl #(
    parameter int unsigned SCK_HALF  = 2,
    parameter int unsigned DUMMY_CYC = 6,
    parameter int unsigned CE_GAP    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [23:0] req_adr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        init_done,
    output logic        sck,
    output logic        ce_n,
    output logic [3:0]  sio_out,
    output logic        sio_oe,
    input  logic [3:0]  sio_in
);

    localparam logic [15:0] HcLast    = 16'(SCK_HALF - 1);
    localparam logic [15:0] DummyLast = 16'(DUMMY_CYC - 1);
    localparam logic [15:0] GapLast   = 16'(CE_GAP - 1);

    typedef enum logic [3:0] {
        StInit, StInitCmd, StIdle, StCmd, StAdr, StWdat, StDummy, StRdat, StDesel
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q;
    logic [15:0] hc_q;
    logic        sck_q;
    logic        shifting;
    logic        sck_fall;
    logic        accept;
    logic        we_q;
    logic [23:0] adr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_nx;
    logic [31:0] rsp_rdata_q;
    logic        rsp_valid_q;
    logic        init_done_q;
    logic [4:0]  nib_off;
    logic [4:0]  adr_off;
    logic [7:0]  opcode;
`ifdef QSPI_INIT_RESET_EN
    logic        init_second_q;
`endif

    assign shifting = state_q inside {StInitCmd, StCmd, StAdr, StWdat, StDummy, StRdat};
    // Clk on which sck goes 1->0: outputs advance and sio_in is captured here.
    assign sck_fall = shifting && sck_q && (hc_q == HcLast);
    assign accept   = (state_q == StIdle) && req_valid;

    // Data nibble k: byte k/2 in address order, high nibble first.
    assign nib_off = {cnt_q[2:1], ~cnt_q[0], 2'b00};
    assign adr_off = 5'd20 - {cnt_q[2:0], 2'b00};

    always_comb begin
        rdata_nx = rdata_q;
        rdata_nx[nib_off +: 4] = sio_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit: begin
`ifdef QSPI_INIT_RESET_EN
                if (cnt_q == 16'd15) state_d = StInitCmd;
`else
                state_d = StIdle;
`endif
            end
            StInitCmd: if (sck_fall && cnt_q == 16'd7) state_d = StDesel;
            StIdle:    if (req_valid) state_d = StCmd;
            StCmd:     if (sck_fall && cnt_q == 16'd7) state_d = StAdr;
            StAdr:     if (sck_fall && cnt_q == 16'd5) state_d = we_q ? StWdat : StDummy;
            StWdat:    if (sck_fall && cnt_q == 16'd7) state_d = StDesel;
            StDummy:   if (sck_fall && cnt_q == DummyLast) state_d = StRdat;
            StRdat:    if (sck_fall && cnt_q == 16'd7) state_d = StDesel;
            StDesel: begin
                if (cnt_q == GapLast) begin
`ifdef QSPI_INIT_RESET_EN
                    state_d = (!init_done_q && !init_second_q) ? StInitCmd : StIdle;
`else
                    state_d = StIdle;
`endif
                end
            end
            default:   state_d = StInit;
        endcase
    end

    always_comb begin
        ce_n      = 1'b1;
        sio_oe    = 1'b0;
        sio_out   = 4'h0;
        req_ready = 1'b0;
        opcode    = we_q ? 8'h38 : 8'hEB;
`ifdef QSPI_INIT_RESET_EN
        if (state_q == StInitCmd) opcode = init_second_q ? 8'h99 : 8'h66;
`endif
        unique case (state_q)
            StIdle: req_ready = 1'b1;
            StInitCmd, StCmd: begin
                ce_n    = 1'b0;
                sio_oe  = 1'b1;
                sio_out = {3'b000, opcode[3'd7 - cnt_q[2:0]]};
            end
            StAdr: begin
                ce_n    = 1'b0;
                sio_oe  = 1'b1;
                sio_out = adr_q[adr_off +: 4];
            end
            StWdat: begin
                ce_n    = 1'b0;
                sio_oe  = 1'b1;
                sio_out = wdata_q[nib_off +: 4];
            end
            StDummy, StRdat: ce_n = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            hc_q          <= '0;
            sck_q         <= 1'b0;
            we_q          <= 1'b0;
            adr_q         <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rsp_rdata_q   <= '0;
            rsp_valid_q   <= 1'b0;
            init_done_q   <= 1'b0;
`ifdef QSPI_INIT_RESET_EN
            init_second_q <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (sck_fall || state_q inside {StInit, StDesel}) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (shifting) begin
                if (hc_q == HcLast) begin
                    hc_q  <= '0;
                    sck_q <= ~sck_q;
                end else begin
                    hc_q <= hc_q + 16'd1;
                end
            end else begin
                hc_q  <= '0;
                sck_q <= 1'b0;
            end
            if (accept) begin
                we_q    <= req_we;
                adr_q   <= {req_adr[23:2], 2'b00};
                wdata_q <= req_wdata;
            end
            if (state_q == StRdat && sck_fall) begin
                rdata_q <= rdata_nx;
                if (cnt_q == 16'd7) begin
                    rsp_rdata_q <= rdata_nx;
                    rsp_valid_q <= 1'b1;
                end
            end
            if (state_d == StIdle) init_done_q <= 1'b1;
`ifdef QSPI_INIT_RESET_EN
            if (state_q == StDesel && state_d == StInitCmd) init_second_q <= 1'b1;
`endif
        end
    end

    assign sck       = sck_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;

endmodule
